tinker_fetch_queue: RTL and testbench

Instruction prefetch stage that sits between instruction memory and the tinker core's decode/control logic. It issues sequential 32-bit fetch requests over a valid/ready memory port and tracks up to DEPTH requests in flight. Returned words are buffered in a FIFO and presented to decode with their PC under a valid/ready handshake. A redirect (taken branch, call, return) flushes buffered instructions, discards in-flight responses and restarts fetching at the new PC.

---
 rtl/tinker_pkg.sv | 20 ++
 rtl/tinker_fetch_queue_if.sv | 32 +++
 rtl/tinker_sync_fifo.sv | 71 +++++++
 rtl/tinker_fetch_queue.sv | 98 +++++++++
 tb/tb_tinker_fetch_queue.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker fetch path.
package tinker_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;

   localparam logic [ADDR_W-1:0] TINKER_RESET_PC = 32'h2000;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Instruction addresses are word aligned; the low two bits are dropped.
   function automatic logic [ADDR_W-1:0] alignPc(input logic [ADDR_W-1:0] pc);
      return {pc[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/tinker_fetch_queue_if.sv
// Memory request/response, decode handshake and redirect signals of the fetch queue.
interface tinker_fetch_queue_if;
   import tinker_pkg::*;

   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_ready;
   logic              mem_rsp_valid;
   logic [INST_W-1:0] mem_rsp_data;
   logic              inst_valid;
   logic [INST_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_ready;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              err_rsp;

   // The fetch queue itself: issues requests and presents instructions.
   modport master (
      output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, err_rsp,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
             redirect_valid, redirect_pc
   );

   // The surroundings: instruction memory plus decode/control.
   modport slave (
      input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, err_rsp,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
             redirect_valid, redirect_pc
   );

endinterface

// File: rtl/tinker_sync_fifo.sv
// Circular-buffer FIFO with combinational head read and a one-cycle flush.
module tinker_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           pushData_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   // Qualify push/pop against occupancy; a full FIFO still takes a push when it pops in the same cycle.
   always_comb begin
      doPop  = pop_i && (count_q != '0) && !flush_i;
      doPush = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || doPop);
   end

   // Next pointers and occupancy; the pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

   assign head_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

endmodule

// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch: credit-limited sequential fetch, response buffering and redirect flush.
module tinker_fetch_queue
   import tinker_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = TINKER_RESET_PC
) (
   input logic                clk,
   input logic                reset,
   tinker_fetch_queue_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
   logic [ADDR_W-1:0] rspPc_q, rspPc_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;
   logic              errRsp_q, errRsp_d;
   logic [CNT_W-1:0]  fifoCount;
   logic [CNT_W:0]    creditUsed;
   logic              reqValid, reqFire;
   logic              rspDrop, rspOrphan, rspPush, rspRetire;
   logic              instPop;
   logic [ADDR_W-1:0] redirectTarget;
   fetch_entry_t      pushEntry, headEntry;

   // Request issue and response classification. Dropped requests keep their credit until they return.
   always_comb begin
      creditUsed     = {1'b0, fifoCount} + {1'b0, outstanding_q};
      reqValid       = reset && !bus.redirect_valid && (creditUsed < (CNT_W+1)'(DEPTH));
      reqFire        = reqValid && bus.mem_req_ready;
      rspDrop        = bus.mem_rsp_valid && (dropCnt_q != '0);
      rspOrphan      = bus.mem_rsp_valid && (dropCnt_q == '0) && (outstanding_q == '0);
      rspPush        = bus.mem_rsp_valid && (dropCnt_q == '0) && (outstanding_q != '0)
                       && !bus.redirect_valid;
      rspRetire      = bus.mem_rsp_valid && (outstanding_q != '0);
      instPop        = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
      redirectTarget = alignPc(bus.redirect_pc);
      pushEntry.pc   = rspPc_q;
      pushEntry.inst = bus.mem_rsp_data;
   end

   // Next-state for the address, credit and drop bookkeeping; a redirect overrides everything.
   always_comb begin
      fetchPc_d     = fetchPc_q;
      rspPc_d       = rspPc_q;
      outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(rspRetire);
      dropCnt_d     = dropCnt_q - CNT_W'(rspDrop);
      errRsp_d      = errRsp_q || rspOrphan;
      if (reqFire) fetchPc_d = fetchPc_q + 32'd4;
      if (rspPush) rspPc_d   = rspPc_q + 32'd4;
      if (bus.redirect_valid) begin
         fetchPc_d = redirectTarget;
         rspPc_d   = redirectTarget;
         dropCnt_d = outstanding_d;
      end
   end

   // Bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetchPc_q     <= RESET_PC;
         rspPc_q       <= RESET_PC;
         outstanding_q <= '0;
         dropCnt_q     <= '0;
         errRsp_q      <= 1'b0;
      end else begin
         fetchPc_q     <= fetchPc_d;
         rspPc_q       <= rspPc_d;
         outstanding_q <= outstanding_d;
         dropCnt_q     <= dropCnt_d;
         errRsp_q      <= errRsp_d;
      end
   end

   tinker_sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (rspPush),
      .pushData_i (pushEntry),
      .pop_i      (instPop),
      .flush_i    (bus.redirect_valid),
      .head_o     (headEntry),
      .count_o    (fifoCount)
   );

   assign bus.mem_req_valid = reqValid;
   assign bus.mem_req_addr  = fetchPc_q;
   assign bus.inst_valid    = (fifoCount != '0);
   assign bus.inst_data     = headEntry.inst;
   assign bus.inst_pc       = headEntry.pc;
   assign bus.err_rsp       = errRsp_q;

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Directed bench for the fetch queue with an in-order memory model and a scoreboard monitor.
module tb_tinker_fetch_queue;

   logic clk;
   logic reset;

   tinker_fetch_queue_if bus();

   tinker_fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h2000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cycleNum = 0;
   int reqCount = 0;
   int memLatency = 1;
   bit injectRsp = 0;
   logic [31:0] pendAddr [$];
   int          pendDue  [$];
   logic [31:0] expQ     [$];

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word the memory model returns for an address.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return {addr[15:0], ~addr[15:0]};
   endfunction

   // Count one comparison and report it if it disagrees.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, actual, required, cycleNum);
      end
   endtask

   // Drive the handshake and redirect inputs for the current cycle.
   task automatic applyStimulus(input bit memReady, input bit instReady,
                                input bit redirValid, input logic [31:0] redirPc);
      bus.mem_req_ready  = memReady;
      bus.inst_ready     = instReady;
      bus.redirect_valid = redirValid;
      bus.redirect_pc    = redirPc;
   endtask

   // Advance one cycle: record accepted requests, then present any due response.
   task automatic tick();
      int dummy;
      @(negedge clk);
      if (reset && bus.mem_req_valid && bus.mem_req_ready) begin
         pendAddr.push_back(bus.mem_req_addr);
         pendDue.push_back(cycleNum + memLatency);
         reqCount++;
      end
      @(posedge clk);
      #1;
      cycleNum++;
      if (injectRsp) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = 32'hBAD0_BAD0;
         injectRsp = 0;
      end else if (pendDue.size() != 0 && pendDue[0] <= cycleNum) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = memWord(pendAddr.pop_front());
         dummy = pendDue.pop_front();
      end else begin
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = '0;
      end
      #1;
   endtask

   // Assert reset, check the reset values, abandon in-flight memory traffic, release.
   task automatic applyReset();
      reset = 1'b0;
      pendAddr.delete();
      pendDue.delete();
      injectRsp = 0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      applyStimulus(0, 0, 0, 32'h0);
      #1;
      checkOutput("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      checkOutput("rst_req_addr", bus.mem_req_addr, 32'h2000);
      checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      checkOutput("rst_inst_data", bus.inst_data, 32'd0);
      checkOutput("rst_inst_pc", bus.inst_pc, 32'd0);
      checkOutput("rst_err_rsp", 32'(bus.err_rsp), 32'd0);
      repeat (3) tick();
      reset = 1'b1;
      #1;
   endtask

   // Scoreboard monitor: every accepted instruction must match the next expected PC.
   initial begin
      logic [31:0] expPc;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_inst actual_pc=%h required=none (cycle %0d)",
                        bus.inst_pc, cycleNum);
            end else begin
               expPc = expQ.pop_front();
               checkOutput("inst_pc", bus.inst_pc, expPc);
               checkOutput("inst_data", bus.inst_data, memWord(expPc));
            end
         end
      end
   end

   // Directed test sequence.
   initial begin
      reset = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      applyStimulus(0, 0, 0, 32'h0);
      #2;

      // Reset and the first request after release.
      applyReset();
      checkOutput("first_req_valid", 32'(bus.mem_req_valid), 32'd1);
      checkOutput("first_req_addr", bus.mem_req_addr, 32'h2000);
      checkOutput("first_inst_valid", 32'(bus.inst_valid), 32'd0);

      // Streaming: eight back-to-back fetches with 1-cycle memory and decode always ready.
      $display("[TB] streaming");
      for (int i = 0; i < 8; i++) expQ.push_back(32'h2000 + 32'(4 * i));
      applyStimulus(1, 1, 0, 32'h0);
      for (int k = 0; k < 10; k++) begin
         if (k == 8) bus.mem_req_ready = 1'b0;
         if (k >= 2) checkOutput("stream_no_bubble", 32'(bus.inst_valid), 32'd1);
         tick();
      end
      checkOutput("stream_empty", 32'(bus.inst_valid), 32'd0);
      checkOutput("stream_drained", 32'(expQ.size()), 32'd0);

      // Backpressure: decode stalled, credit caps fetch at four.
      $display("[TB] backpressure");
      applyReset();
      reqCount = 0;
      applyStimulus(1, 0, 0, 32'h0);
      repeat (8) tick();
      checkOutput("bp_req_count", 32'(reqCount), 32'd4);
      checkOutput("bp_full_no_req", 32'(bus.mem_req_valid), 32'd0);
      checkOutput("bp_head_pc", bus.inst_pc, 32'h2000);
      expQ.push_back(32'h2000);
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      checkOutput("bp_pop_req_valid", 32'(bus.mem_req_valid), 32'd1);
      checkOutput("bp_pop_req_addr", bus.mem_req_addr, 32'h2010);
      repeat (3) tick();
      checkOutput("bp_one_more_req", 32'(reqCount), 32'd5);
      checkOutput("bp_refull_no_req", 32'(bus.mem_req_valid), 32'd0);
      for (int i = 1; i <= 4; i++) expQ.push_back(32'h2000 + 32'(4 * i));
      applyStimulus(0, 1, 0, 32'h0);
      repeat (4) tick();
      checkOutput("bp_empty", 32'(bus.inst_valid), 32'd0);
      checkOutput("bp_drained", 32'(expQ.size()), 32'd0);

      // Redirect with two requests in flight (3-cycle memory): both stale responses are dropped.
      $display("[TB] redirect with outstanding requests");
      applyReset();
      memLatency = 3;
      applyStimulus(1, 1, 0, 32'h0);
      repeat (2) tick();
      applyStimulus(0, 1, 1, 32'h3001);
      #1;
      checkOutput("redir_blocks_req", 32'(bus.mem_req_valid), 32'd0);
      for (int i = 0; i < 3; i++) expQ.push_back(32'h3000 + 32'(4 * i));
      tick();
      applyStimulus(1, 1, 0, 32'h0);
      #1;
      checkOutput("redir_req_valid", 32'(bus.mem_req_valid), 32'd1);
      checkOutput("redir_req_addr", bus.mem_req_addr, 32'h3000);
      for (int k = 3; k < 12; k++) begin
         if (k == 6) bus.mem_req_ready = 1'b0;
         if (k >= 4 && k <= 6) checkOutput("redir_stale_hidden", 32'(bus.inst_valid), 32'd0);
         if (k == 7) begin
            checkOutput("redir_first_valid", 32'(bus.inst_valid), 32'd1);
            checkOutput("redir_first_pc", bus.inst_pc, 32'h3000);
         end
         tick();
      end
      checkOutput("redir_drained", 32'(expQ.size()), 32'd0);
      checkOutput("redir_no_err", 32'(bus.err_rsp), 32'd0);
      memLatency = 1;

      // Redirect coinciding with a response and a pop while three entries are buffered.
      $display("[TB] redirect with response and pop");
      applyReset();
      applyStimulus(1, 0, 0, 32'h0);
      repeat (4) tick();
      applyStimulus(0, 1, 1, 32'h4000);
      #1;
      checkOutput("combo_head_pc", bus.inst_pc, 32'h2000);
      checkOutput("combo_rsp_present", 32'(bus.mem_rsp_valid), 32'd1);
      tick();
      applyStimulus(1, 1, 0, 32'h0);
      #1;
      checkOutput("combo_flushed", 32'(bus.inst_valid), 32'd0);
      checkOutput("combo_req_valid", 32'(bus.mem_req_valid), 32'd1);
      checkOutput("combo_req_addr", bus.mem_req_addr, 32'h4000);
      expQ.push_back(32'h4000);
      expQ.push_back(32'h4004);
      repeat (2) tick();
      bus.mem_req_ready = 1'b0;
      repeat (4) tick();
      checkOutput("combo_drained", 32'(expQ.size()), 32'd0);

      // Orphan response: discarded and flags a sticky error.
      $display("[TB] orphan response");
      checkOutput("err_clear_before", 32'(bus.err_rsp), 32'd0);
      injectRsp = 1;
      tick();
      tick();
      checkOutput("err_set", 32'(bus.err_rsp), 32'd1);
      checkOutput("err_word_dropped", 32'(bus.inst_valid), 32'd0);
      repeat (2) tick();
      checkOutput("err_sticky", 32'(bus.err_rsp), 32'd1);

      // Reset in the middle of traffic, then a clean restart from the reset PC.
      $display("[TB] mid-stream reset");
      applyStimulus(1, 0, 0, 32'h0);
      repeat (3) tick();
      applyReset();
      checkOutput("restart_req_addr", bus.mem_req_addr, 32'h2000);
      checkOutput("restart_err_clear", 32'(bus.err_rsp), 32'd0);
      expQ.push_back(32'h2000);
      applyStimulus(1, 1, 0, 32'h0);
      tick();
      bus.mem_req_ready = 1'b0;
      repeat (3) tick();
      checkOutput("restart_drained", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
